// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module : seg_scan_ctrl
// | Brief  : 4-digit multiplexed 7-seg scan controller with frame-coherent
// |          double-buffered display value. Optional macro: SEG_LZ_BLANK_EN.
// | Rev    : 1.0
// +-----------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  output logic [3:0] q0,
  output logic [3:0] q1,
  output logic [3:0] q2,
  output logic [3:0] q3,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic       tick,
  output logic       pending
);

  localparam int unsigned PRESC_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(REFRESH_DIV - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [1:0]         sel_q, sel_d;
  logic [3:0]         an_q, an_d;
  logic               tick_q, tick_d;
  logic               pending_q, pending_d;
  logic [15:0]        disp_q, disp_d;
  logic [15:0]        shadow_q, shadow_d;
  logic               adv;
  logic               swap;

  always_comb begin
    adv       = (presc_q == PRESC_MAX);
    presc_d   = adv ? '0 : presc_q + 1'b1;
    sel_d     = adv ? sel_q + 2'd1 : sel_q;
    tick_d    = adv;
    // Swap only on the 3->0 boundary so a frame never mixes old and new digits.
    swap      = adv && (sel_q == 2'd3) && pending_q;
    disp_d    = swap ? shadow_q : disp_q;
    shadow_d  = load ? {d3, d2, d1, d0} : shadow_q;
    pending_d = load | (pending_q & ~swap);
    an_d      = ~(4'b0001 << sel_d);
`ifdef SEG_LZ_BLANK_EN
    if (disp_d[15:12] == 4'd0) an_d[3] = 1'b1;
    if (disp_d[15:8]  == 8'd0) an_d[2] = 1'b1;
    if (disp_d[15:4]  == 12'd0) an_d[1] = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q   <= '0;
      sel_q     <= 2'd0;
      an_q      <= 4'b1110;
      tick_q    <= 1'b0;
      pending_q <= 1'b0;
      disp_q    <= 16'd0;
      shadow_q  <= 16'd0;
    end else begin
      presc_q   <= presc_d;
      sel_q     <= sel_d;
      an_q      <= an_d;
      tick_q    <= tick_d;
      pending_q <= pending_d;
      disp_q    <= disp_d;
      shadow_q  <= shadow_d;
    end
  end

  assign q0      = disp_q[3:0];
  assign q1      = disp_q[7:4];
  assign q2      = disp_q[11:8];
  assign q3      = disp_q[15:12];
  assign sel     = sel_q;
  assign an      = an_q;
  assign tick    = tick_q;
  assign pending = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// Self-checking bench for seg_scan_ctrl with REFRESH_DIV = 4.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] d_all;
  logic [3:0]  q0, q1, q2, q3;
  logic [1:0]  sel;
  logic [3:0]  an;
  logic        tick;
  logic        pending;
  logic [15:0] q_all;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] d_first;
    logic        two_loads;
    logic [15:0] d_second;
    logic [15:0] exp_q;
  } vec_t;

  vec_t vecs [4];

  seg_scan_ctrl #(.REFRESH_DIV(4)) dut (
    .clk(clk), .reset(reset), .load(load),
    .d0(d_all[3:0]), .d1(d_all[7:4]), .d2(d_all[11:8]), .d3(d_all[15:12]),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .sel(sel), .an(an), .tick(tick), .pending(pending)
  );

  assign q_all = {q3, q2, q1, q0};

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_an(input logic [1:0] s, input logic [15:0] q);
    logic [3:0] a;
    a    = 4'b1111;
    a[s] = 1'b0;
`ifdef SEG_LZ_BLANK_EN
    if (q[15:12] == 4'd0) a[3] = 1'b1;
    if (q[15:8]  == 8'd0) a[2] = 1'b1;
    if (q[15:4]  == 12'd0) a[1] = 1'b1;
`endif
    return a;
  endfunction

  // Step until sel has just advanced to s (tick high), bounded.
  task automatic wait_adv(input logic [1:0] s);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(sel == s && tick == 1'b1) && n < 64);
    if (!(sel == s && tick == 1'b1)) begin
      tests++;
      fails++;
      $display("FAIL wait_adv: timed out, sel=%0d required %0d", sel, s);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    d_all = v;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  initial begin
    logic [15:0] old_q;

    vecs[0] = '{d_first: 16'h4321, two_loads: 1'b0, d_second: 16'h0000, exp_q: 16'h4321};
    vecs[1] = '{d_first: 16'h8765, two_loads: 1'b1, d_second: 16'h1009, exp_q: 16'h1009};
    vecs[2] = '{d_first: 16'h0000, two_loads: 1'b0, d_second: 16'h0000, exp_q: 16'h0000};
    vecs[3] = '{d_first: 16'h9999, two_loads: 1'b1, d_second: 16'h5050, exp_q: 16'h5050};

    reset = 1'b1;
    load  = 1'b0;
    d_all = 16'h0000;
    repeat (3) step();
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_an", 32'(an), 32'b1110);
    chk("rst_q", 32'(q_all), 32'h0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);

    // Free-running scan with changing d but no load: q must hold 0.
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      d_all = 16'($urandom);
      step();
      chk($sformatf("scan_sel_%0d", k), 32'(sel), 32'((k / 4) % 4));
      chk($sformatf("scan_tick_%0d", k), 32'(tick), 32'(k % 4 == 0));
      chk($sformatf("scan_an_%0d", k), 32'(an), 32'(exp_an(2'((k / 4) % 4), 16'h0)));
    end
    chk("scan_q_hold", 32'(q_all), 32'h0);

    old_q = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      wait_adv(2'd1);
      do_load(vecs[i].d_first);
      chk($sformatf("v%0d_pending", i), 32'(pending), 32'd1);
      chk($sformatf("v%0d_q_held", i), 32'(q_all), 32'(old_q));
      if (vecs[i].two_loads) begin
        step();
        do_load(vecs[i].d_second);
        chk($sformatf("v%0d_pending2", i), 32'(pending), 32'd1);
      end
      d_all = 16'($urandom);
      wait_adv(2'd3);
      chk($sformatf("v%0d_q_pre_wrap", i), 32'(q_all), 32'(old_q));
      wait_adv(2'd0);
      chk($sformatf("v%0d_q_swap", i), 32'(q_all), 32'(vecs[i].exp_q));
      chk($sformatf("v%0d_pending_clr", i), 32'(pending), 32'd0);
      chk($sformatf("v%0d_an", i), 32'(an), 32'(exp_an(2'd0, vecs[i].exp_q)));
      old_q = vecs[i].exp_q;
    end

    // Load landing on the swap edge: old shadow shown, new one stays pending.
    wait_adv(2'd1);
    do_load(16'h1111);
    wait_adv(2'd3);
    repeat (3) step();
    do_load(16'hAAAA);
    chk("coinc_sel", 32'(sel), 32'd0);
    chk("coinc_q", 32'(q_all), 32'h1111);
    chk("coinc_pending", 32'(pending), 32'd1);
    wait_adv(2'd0);
    chk("coinc_q_next", 32'(q_all), 32'hAAAA);
    chk("coinc_pending_clr", 32'(pending), 32'd0);

    // Reset mid-frame with a pending value, load asserted alongside reset.
    wait_adv(2'd1);
    do_load(16'h5555);
    wait_adv(2'd2);
    chk("mid_pending", 32'(pending), 32'd1);
    reset = 1'b1;
    d_all = 16'h7777;
    load  = 1'b1;
    step();
    reset = 1'b0;
    load  = 1'b0;
    chk("mrst_sel", 32'(sel), 32'd0);
    chk("mrst_an", 32'(an), 32'b1110);
    chk("mrst_q", 32'(q_all), 32'h0);
    chk("mrst_pending", 32'(pending), 32'd0);
    chk("mrst_tick", 32'(tick), 32'd0);
    repeat (3) step();
    chk("mrst_sel_hold", 32'(sel), 32'd0);
    step();
    chk("mrst_sel_adv", 32'(sel), 32'd1);
    chk("mrst_tick_adv", 32'(tick), 32'd1);
    wait_adv(2'd0);
    chk("mrst_q_discard", 32'(q_all), 32'h0);
    chk("mrst_pending_off", 32'(pending), 32'd0);

`ifdef SEG_LZ_BLANK_EN
    wait_adv(2'd1);
    do_load(16'h0007);
    wait_adv(2'd0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("lz7_an_%0d", k), 32'(an[3:1]), 32'b111);
      step();
    end
    wait_adv(2'd1);
    do_load(16'h0507);
    wait_adv(2'd0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("lz507_an3_%0d", k), 32'(an[3]), 32'd1);
      chk($sformatf("lz507_an2_%0d", k), 32'(an[2]), 32'(sel != 2'd2));
      step();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clk cycles per digit slot (legal 2..2^24).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port load  input  1  one-cycle strobe: capture d3..d0 as the next display value.
REQ-005 SHALL have ports d0, d1, d2, d3  input  4 each  BCD nibbles; d0 = least significant digit.
REQ-006 SHALL have ports q0, q1, q2, q3  output  4 each  displayed nibbles, fed to the 4:1 digit mux data inputs.
REQ-007 SHALL have port sel  output  2  digit index, fed to the mux select.
REQ-008 SHALL have port an  output  4  active-low anode enables; bit i drives digit i.
REQ-009 SHALL have port tick  output  1  one-cycle pulse on every digit advance.
REQ-010 SHALL have port pending  output  1  high while a loaded value awaits frame swap.

Function
REQ-011 SHALL count the prescaler from 0 to REFRESH_DIV-1, then wrap to 0; width fits REFRESH_DIV-1.
REQ-012 SHALL, in the cycle after the prescaler reaches REFRESH_DIV-1, advance sel by 1 (3 wraps to 0) and assert tick for exactly one cycle.
REQ-013 SHALL register an in the same cycle as sel so that an == ~(1<<sel) at all times (subject to REQ-019); never more than one anode low.
REQ-014 SHALL, on load, write d3..d0 into shadow registers and set pending the next cycle.
REQ-015 SHALL swap shadow into q3..q0 and clear pending only in the cycle sel wraps 3->0 with pending set (frame-coherent, no tearing mid-scan).
REQ-016 SHALL, when load coincides with the swap cycle, move the pre-existing shadow to q, write the new d into shadow, and leave pending set.
REQ-017 SHALL, on repeated load while pending, overwrite shadow (last load wins); only one swap occurs.
REQ-018 SHALL hold q3..q0 constant between swaps regardless of d inputs.

Reset
REQ-019 SHALL, while reset is high at a clock edge, set prescaler=0, sel=0, an=4'b1110, q0..q3=0, shadow=0, pending=0, tick=0; reset overrides load.
REQ-020 SHALL, on reset mid-frame or mid-pending, discard shadow and restart scanning at digit 0 on the first cycle after reset deasserts.

Configuration
REQ-021 SHALL support macro SEG_LZ_BLANK_EN; when defined, an bit i (i=3..1) is forced high whenever qi and all higher q nibbles are 0; digit 0 is never blanked; sel/tick timing unchanged.
REQ-022 SHALL, when SEG_LZ_BLANK_EN is undefined, drive all four anodes per REQ-013 with no blanking logic present.

Verification (REFRESH_DIV=4)
REQ-023 Release reset -> sel 0,1,2,3,0 advancing every 4 cycles; tick pulses once per advance; an 1110,1101,1011,0111,1110.
REQ-024 load with d=4'h1,2,3,4 (d0..d3) at sel=1 -> pending=1; q unchanged until sel 3->0, then q0..q3=1,2,3,4, pending=0.
REQ-025 load d=5,6,7,8 then d=9,0,0,1 before the wrap -> single swap shows 9,0,0,1.
REQ-026 load d=A in the swap cycle while pending with 1,1,1,1 -> q=1,1,1,1 that cycle; pending stays 1; q=A values at next wrap.
REQ-027 reset asserted at sel=2 with pending=1 -> next cycle sel=0, an=1110, q all 0, pending=0.
REQ-028 With SEG_LZ_BLANK_EN, q0..q3=7,0,0,0 -> an bits 3..1 stay high all frame; with q=7,0,5,0 -> only an[3] blanked.
